pixel_column_reader: RTL and testbench
======================================

# pixel_column_reader

Memory-side responder for the Sobel edge detection controller's `start_read`/`read_done` handshake. On each `start_read` it fetches one 3-pixel image column from pixel memory over a request/acknowledge interface. It shifts that column into a 3x3 window register and pulses `read_done` once the window is updated. The window feeds the Sobel calculation stage.

## Interface
- `ADDR_W`, default 16: pixel memory address width.
- `PIX_W`, default 8: pixel width in bits.
- `IMG_WIDTH`, default 640: row stride in pixels between vertically adjacent pixels.
- `clk` in 1: clock, rising edge.
- `n_rst` in 1: reset, asynchronous, active-low.
- `start_read` in 1: fetch request from the controller; sampled only in IDLE.
- `base_addr` in `ADDR_W`: address of the column's top pixel; captured with `start_read`.
- `read_done` out 1: one-cycle pulse; window holds the new column.
- `busy` out 1: high in every state except IDLE.
- `mem_read` out 1: memory read request; held high until acknowledged.
- `mem_addr` out `ADDR_W`: read address; stable while `mem_read` is high.
- `mem_ack` in 1: `mem_rdata` is valid this cycle for the current request.
- `mem_rdata` in `PIX_W`: read data.
- `window` out 9*`PIX_W`: pixel at row r, col c is `window[PIX_W*(3*r+c) +: PIX_W]`; col 2 is the newest column.

## Operation
- States: IDLE, REQ0, REQ1, REQ2, SHIFT, DONE.
- IDLE, `start_read`=1: latch `base_addr` into `addr_q`, go to REQ0. `start_read` in any other state is ignored.
- REQn (n=0..2):
  - `mem_read`=1 and `mem_addr` = `addr_q` + n*`IMG_WIDTH`, truncated to `ADDR_W` (wraps modulo 2^`ADDR_W`).
  - On `mem_ack`, capture `mem_rdata` into `col[n]` and advance (REQ2 advances to SHIFT). Without `mem_ack`, stay in the state.
- SHIFT: for every row r, col0←col1 and col1←col2; col2 row r ←`col[r]`. Go to DONE.
- DONE: `read_done`=1, then go to IDLE.
- `mem_ack` outside REQ states is ignored.
- `window` changes only in SHIFT. Data is never cleared between fetches; the first two fetches of a row prime the window.
- Reset, including mid-operation: state=IDLE; `addr_q`, `col[*]` and `window` = 0.

## Timing
- Reset value of every output is 0: `read_done`, `busy`, `mem_read`, `mem_addr`, `window`, and `read_err` when present.
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.
- `start_read` sampled at edge 0 → REQ0 from edge 1.
- With `mem_ack` high in the first cycle of every request: REQ1 at edge 2, REQ2 at edge 3, SHIFT at edge 4, DONE at edge 5. So `read_done` is high in cycle 5 with `window` already updated.
- Each memory wait cycle adds one cycle of latency.
- `busy` falls in the cycle after `read_done`. A `start_read` in that cycle is accepted, giving back-to-back throughput of one column per 6 cycles.

## Configuration
- `SOBEL_READ_TIMEOUT_EN` defined:
  - Adds output `read_err` (1 bit) and an 8-bit wait counter, cleared on entry to each REQ state.
  - When the counter reaches 255 without `mem_ack`: drop `mem_read` and skip SHIFT (the window is unchanged). Go to DONE, where `read_done` and `read_err` pulse together.
- `SOBEL_READ_TIMEOUT_EN` undefined: the `read_err` port and counter are absent, and the block waits for `mem_ack` indefinitely.

## Structure
- `sobel_pkg` holds:
  - `reader_state_t` enum (IDLE..DONE, 3 bits).
  - `READ_TIMEOUT_CYCLES` = 255.
  - Window index constants `WIN_ROWS` = 3 and `WIN_COLS` = 3.
- Sub-module `window_shift_reg` implements the 3x3 register with a shift-enable and a 3-pixel column input. The FSM, address generation and timeout stay in `pixel_column_reader`.

## Test plan
- Zero-wait fetch: `base_addr`=0x0100, memory returns 0x11/0x22/0x33 at 0x0100/0x0380/0x0600 → `mem_addr` follows that sequence; `read_done` in cycle 5; window col2 = {0x11,0x22,0x33}.
- Three successive fetches with columns A, B, C → after the third `read_done`, cols 0/1/2 = A/B/C. A fourth fetch with D → A is dropped.
- Wait states: `mem_ack` delayed 3 cycles on REQ1 → `mem_addr` stable throughout, `read_done` in cycle 8. A `start_read` pulse during `busy` is ignored.
- Address wrap: `base_addr`=0xFD00 → REQ1 address 0xFF80, REQ2 address 0x0200.
- `n_rst` asserted during REQ2 → all outputs 0 immediately. After release, a new fetch completes normally with col0/col1 = 0.
- `SOBEL_READ_TIMEOUT_EN`, no `mem_ack` in REQ0 → `mem_read` falls after 255 cycles; `read_done` and `read_err` pulse together; `window` unchanged.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel pixel column reader.
package sobel_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        REQ1  = 3'd2,
        REQ2  = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } reader_state_t;

    localparam int READ_TIMEOUT_CYCLES = 255;
    localparam int WIN_ROWS            = 3;
    localparam int WIN_COLS            = 3;

endpackage

// File: rtl/window_shift_reg.sv
// 3x3 pixel window; on shift_en every row moves one column left and the
// incoming 3-pixel column lands in column 2 (newest).
module window_shift_reg
    import sobel_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic                                 clk,
    input  logic                                 n_rst,
    input  logic                                 shift_en,
    input  logic [WIN_ROWS*PIX_W-1:0]            col_in,
    output logic [WIN_ROWS*WIN_COLS*PIX_W-1:0]   window
);

    logic [WIN_ROWS*WIN_COLS*PIX_W-1:0] win_q, win_d;

    always_comb begin
        win_d = win_q;
        if (shift_en) begin
            for (int r = 0; r < WIN_ROWS; r++) begin
                for (int c = 0; c < WIN_COLS; c++) begin
                    if (c < WIN_COLS - 1)
                        win_d[PIX_W*(WIN_COLS*r+c) +: PIX_W] = win_q[PIX_W*(WIN_COLS*r+c+1) +: PIX_W];
                    else
                        win_d[PIX_W*(WIN_COLS*r+c) +: PIX_W] = col_in[PIX_W*r +: PIX_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) win_q <= '0;
        else        win_q <= win_d;
    end

    assign window = win_q;

endmodule

// File: rtl/pixel_column_reader.sv
// Fetches one 3-pixel column per start_read and shifts it into the 3x3 window.
// Optional read timeout with read_err output: define SOBEL_READ_TIMEOUT_EN.
module pixel_column_reader
    import sobel_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int PIX_W     = 8,
    parameter int IMG_WIDTH = 640
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start_read,
    input  logic [ADDR_W-1:0]    base_addr,
    output logic                 read_done,
    output logic                 busy,
    output logic                 mem_read,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic                 mem_ack,
    input  logic [PIX_W-1:0]     mem_rdata,
    output logic [9*PIX_W-1:0]   window
`ifdef SOBEL_READ_TIMEOUT_EN
    ,
    output logic                 read_err
`endif
);

    reader_state_t                state_q, state_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic [WIN_ROWS*PIX_W-1:0]    col_q, col_d;
    logic                         mem_read_q, busy_q, done_q;
    logic [ADDR_W-1:0]            mem_addr_q;
    logic [1:0]                   row;
`ifdef SOBEL_READ_TIMEOUT_EN
    logic [7:0]                   cnt_q, cnt_d;
    logic                         err_q, err_d;
`endif

    function automatic logic [ADDR_W-1:0] req_addr(input reader_state_t s,
                                                   input logic [ADDR_W-1:0] base);
        case (s)
            REQ0:    return base;
            REQ1:    return base + ADDR_W'(IMG_WIDTH);
            REQ2:    return base + ADDR_W'(2 * IMG_WIDTH);
            default: return '0;
        endcase
    endfunction

    function automatic logic is_req(input reader_state_t s);
        return (s == REQ0) || (s == REQ1) || (s == REQ2);
    endfunction

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        col_d   = col_q;
        row     = 2'd0;
`ifdef SOBEL_READ_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start_read) begin
                    addr_d  = base_addr;
                    state_d = REQ0;
`ifdef SOBEL_READ_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            REQ0, REQ1, REQ2: begin
                row = (state_q == REQ0) ? 2'd0 : (state_q == REQ1) ? 2'd1 : 2'd2;
                if (mem_ack) begin
                    col_d[PIX_W*row +: PIX_W] = mem_rdata;
                    state_d = (state_q == REQ0) ? REQ1 : (state_q == REQ1) ? REQ2 : SHIFT;
`ifdef SOBEL_READ_TIMEOUT_EN
                    cnt_d   = '0;
                end else if (cnt_q == 8'(READ_TIMEOUT_CYCLES - 1)) begin
                    // Give up on this column: window stays as it was.
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
`endif
                end
            end
            SHIFT:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with state_q.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            col_q      <= '0;
            mem_read_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_addr_q <= '0;
`ifdef SOBEL_READ_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            col_q      <= col_d;
            mem_read_q <= is_req(state_d);
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == DONE);
            mem_addr_q <= req_addr(state_d, addr_d);
`ifdef SOBEL_READ_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign read_done = done_q;
    assign busy      = busy_q;
    assign mem_read  = mem_read_q;
    assign mem_addr  = mem_addr_q;
`ifdef SOBEL_READ_TIMEOUT_EN
    assign read_err  = err_q;
`endif

    window_shift_reg #(.PIX_W(PIX_W)) u_win (
        .clk      (clk),
        .n_rst    (n_rst),
        .shift_en (state_q == SHIFT),
        .col_in   (col_q),
        .window   (window)
    );

endmodule

// File: tb/tb_pixel_column_reader.sv
// Randomized self-checking bench for pixel_column_reader against a column-queue window model.
module tb_pixel_column_reader;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start_read;
    logic [15:0] base_addr;
    logic        read_done;
    logic        busy;
    logic        mem_read;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [71:0] window;
`ifdef SOBEL_READ_TIMEOUT_EN
    logic        read_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:65535];
    logic [7:0] mwin [3][3];   // [col][row], col 2 newest

    always #5 clk = ~clk;

    pixel_column_reader #(.ADDR_W(16), .PIX_W(8), .IMG_WIDTH(640)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start_read (start_read),
        .base_addr  (base_addr),
        .read_done  (read_done),
        .busy       (busy),
        .mem_read   (mem_read),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .window     (window)
`ifdef SOBEL_READ_TIMEOUT_EN
        ,
        .read_err   (read_err)
`endif
    );

    function automatic logic [71:0] model_vec();
        logic [71:0] v;
        v = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                v[8*(3*r+c) +: 8] = mwin[c][r];
        return v;
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++)
                mwin[c][r] = 8'h00;
    endfunction

    // One fetch; starts in the current (negedge) cycle, returns at the negedge after read_done.
    task automatic do_fetch(input logic [15:0] base, input int w0, input int w1, input int w2,
                            input int ign_cyc, input string name);
        int          waits[3];
        int          k, c, exp_done;
        bit          done;
        logic [15:0] exp_addr;
        logic [71:0] prev_win;
        logic [7:0]  got[3];
        waits    = '{w0, w1, w2};
        exp_done = 5 + w0 + w1 + w2;
        prev_win = model_vec();
        got      = '{8'h00, 8'h00, 8'h00};
        checks++;
        if (busy !== 1'b0 || read_done !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_before_start: busy=%b read_done=%b expected 0/0", name, busy, read_done);
        end
        start_read = 1'b1;
        base_addr  = base;
        @(posedge clk);
        #1;
        start_read = 1'b0;
        base_addr  = 16'($urandom);
        k = 0; c = 1; done = 0;
        while (!done && c < 2000) begin
            @(negedge clk);
            checks++;
            if (busy !== (c <= exp_done)) begin
                errors++;
                $display("FAIL %s busy c%0d: got %b expected %b", name, c, busy, (c <= exp_done));
            end
            if (read_done) begin
                done = 1;
                checks++;
                if (c != exp_done) begin
                    errors++;
                    $display("FAIL %s done_cycle: got %0d expected %0d", name, c, exp_done);
                end
                for (int r = 0; r < 3; r++) begin
                    mwin[0][r] = mwin[1][r];
                    mwin[1][r] = mwin[2][r];
                    mwin[2][r] = got[r];
                end
                checks++;
                if (window !== model_vec()) begin
                    errors++;
                    $display("FAIL %s window: got %h expected %h", name, window, model_vec());
                end
`ifdef SOBEL_READ_TIMEOUT_EN
                checks++;
                if (read_err !== 1'b0) begin
                    errors++;
                    $display("FAIL %s read_err: got %b expected 0", name, read_err);
                end
`endif
            end else begin
                checks++;
                if (window !== prev_win) begin
                    errors++;
                    $display("FAIL %s window_early c%0d: got %h expected %h", name, c, window, prev_win);
                end
            end
            if (mem_read) begin
                if (k > 2) begin
                    checks++; errors++;
                    $display("FAIL %s extra_request: got req %0d expected at most 2", name, k);
                    mem_ack = 1'b0;
                end else begin
                    exp_addr = base + 16'(k * 640);
                    checks++;
                    if (mem_addr !== exp_addr) begin
                        errors++;
                        $display("FAIL %s mem_addr req%0d: got %h expected %h", name, k, mem_addr, exp_addr);
                    end
                    if (waits[k] > 0) begin
                        waits[k]--;
                        mem_ack   = 1'b0;
                        mem_rdata = 8'($urandom);
                    end else begin
                        mem_ack   = 1'b1;
                        mem_rdata = mem[exp_addr];
                        got[k]    = mem[exp_addr];
                        k++;
                    end
                end
            end else begin
                mem_ack   = 1'($urandom);
                mem_rdata = 8'($urandom);
            end
            if (c == ign_cyc) begin
                start_read = 1'b1;
                base_addr  = 16'($urandom);
            end else begin
                start_read = 1'b0;
            end
            if (!done) begin
                @(posedge clk);
                c++;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s read_done_timeout: got none expected cycle %0d", name, exp_done);
        end
        mem_ack    = 1'b0;
        start_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (read_done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse_width: got %b expected 0", name, read_done);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0; start_read = 1'b0; base_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
        model_clear();
        repeat (3) @(negedge clk);
        checks++;
        if ({read_done, busy, mem_read, mem_addr, window} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {read_done, busy, mem_read, mem_addr, window});
        end
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_wait();
        mem[16'h0100] = 8'h11;
        mem[16'h0380] = 8'h22;
        mem[16'h0600] = 8'h33;
        do_fetch(16'h0100, 0, 0, 0, -1, "zero_wait");
        checks++;
        if ({window[8*8 +: 8], window[8*5 +: 8], window[8*2 +: 8]} !== 24'h332211) begin
            errors++;
            $display("FAIL zero_wait_col2: got %h expected 332211",
                     {window[8*8 +: 8], window[8*5 +: 8], window[8*2 +: 8]});
        end
    endtask

    task automatic test_back_to_back();
        logic [71:0] after_c;
        for (int i = 0; i < 3; i++)
            do_fetch(16'($urandom), 0, 0, 0, -1, "b2b");
        after_c = window;
        do_fetch(16'($urandom), 0, 0, 0, -1, "b2b_fourth");
        checks++;
        if (window[8*0 +: 16] !== after_c[8*1 +: 16] || window[8*3 +: 16] !== after_c[8*4 +: 16] ||
            window[8*6 +: 16] !== after_c[8*7 +: 16]) begin
            errors++;
            $display("FAIL b2b_drop_oldest: got %h expected cols0/1 from %h", window, after_c);
        end
    endtask

    task automatic test_wait_states();
        do_fetch(16'($urandom), 0, 3, 0, 3, "wait_req1");
    endtask

    task automatic test_addr_wrap();
        do_fetch(16'hFD00, 0, 0, 0, -1, "wrap");
    endtask

    task automatic test_reset_mid();
        logic [15:0] b;
        b = 16'($urandom);
        start_read = 1'b1; base_addr = b;
        @(posedge clk); #1; start_read = 1'b0;
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 8'($urandom);
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 8'($urandom);
        @(negedge clk); mem_ack = 1'b0;
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 16'(b + 16'd1280)) begin
            errors++;
            $display("FAIL reset_mid_in_req2: got rd=%b addr=%h expected 1/%h", mem_read, mem_addr, 16'(b + 16'd1280));
        end
        n_rst = 1'b0;
        #1;
        model_clear();
        checks++;
        if ({read_done, busy, mem_read, mem_addr, window} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h expected 0", {read_done, busy, mem_read, mem_addr, window});
        end
        @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        do_fetch(16'($urandom), 0, 0, 0, -1, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            do_fetch(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     ($urandom_range(0, 1) != 0) ? 2 : -1, "random");
    endtask

`ifdef SOBEL_READ_TIMEOUT_EN
    task automatic test_timeout();
        int  n_high, c;
        bit  done;
        logic [71:0] prev_win;
        prev_win = model_vec();
        start_read = 1'b1; base_addr = 16'($urandom);
        @(posedge clk); #1; start_read = 1'b0;
        n_high = 0; c = 0; done = 0;
        while (!done && c < 600) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_read) n_high++;
            if (read_done) begin
                done = 1;
                checks++;
                if (read_err !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_err: got %b expected 1", read_err);
                end
                checks++;
                if (n_high != 255) begin
                    errors++;
                    $display("FAIL timeout_len: got %0d expected 255", n_high);
                end
                checks++;
                if (window !== prev_win) begin
                    errors++;
                    $display("FAIL timeout_window: got %h expected %h", window, prev_win);
                end
            end else begin
                @(posedge clk);
                c++;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout_no_done: got none expected read_done");
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (read_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_after: got err=%b busy=%b expected 0/0", read_err, busy);
        end
    endtask
`endif

    initial begin
        for (int a = 0; a < 65536; a++)
            mem[a] = 8'($urandom);
        test_reset();
        test_zero_wait();
        test_back_to_back();
        test_wait_states();
        test_addr_wrap();
        test_reset_mid();
`ifdef SOBEL_READ_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2000000");
        $fatal(1, "watchdog expired");
    end

endmodule
